// File: rtl/mnist_nn_led_fader.sv
// -----------------------------------------------------------------------------
// mnist_nn_led_fader
//
// Sits between the LED PIO out_port and the board LED pins. Each bit of the
// incoming pattern becomes a smoothly faded LED. Every channel owns a
// saturating brightness level that walks one step per fade tick toward
// full-on (MAX) or off (0). All channels share one free-running PWM counter
// that renders the levels as duty cycles.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   enable     1 = fade/PWM mode, 0 = bypass (led_out follows led_in, 2 cycles)
//   led_in     target pattern from the PIO out_port
//   led_out    registered LED drive, 1 = lit
//   fade_done  (only with LED_FADE_DONE_EN) one-cycle pulse after every
//              channel has settled at its target level
//
// Optional feature macro: LED_FADE_DONE_EN
// -----------------------------------------------------------------------------
module mnist_nn_led_fader #(
    parameter int NUM_LEDS = 14,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] led_out
`ifdef LED_FADE_DONE_EN
    ,
    output logic                fade_done
`endif
);

    // A 1-bit prescaler is kept even for STEP_DIV==1 so the vector is legal;
    // in that case it stays at 0 and tick fires every enabled cycle.
    localparam int PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] LEVEL_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 1);

    logic [NUM_LEDS-1:0]                led_q_reg;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  level_reg;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  level_next;
    logic [PWM_BITS-1:0]                pwm_cnt_reg;
    logic [PRESC_W-1:0]                 presc_reg;
    logic [NUM_LEDS-1:0]                led_out_reg;
    logic [NUM_LEDS-1:0]                led_out_next;
    logic                               tick;

    // Fade tick: one cycle in every STEP_DIV enabled cycles. Disabling the
    // block suppresses it, which is what freezes the levels in bypass.
    always_comb begin
        tick = enable && (presc_reg == PRESC_LAST);
    end

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
            // Saturating one-step move toward the current target; a target
            // flip mid-ramp simply reverses direction from where it is.
            assign level_next[gi] =
                !tick                                          ? level_reg[gi] :
                (led_q_reg[gi]  && (level_reg[gi] != LEVEL_MAX)) ? level_reg[gi] + PWM_BITS'(1) :
                (!led_q_reg[gi] && (level_reg[gi] != '0))        ? level_reg[gi] - PWM_BITS'(1) :
                                                                  level_reg[gi];

            // MAX is forced on so a fully faded-in LED never blinks off at the
            // counter's top value; level 0 can never exceed the counter.
            assign led_out_next[gi] = enable
                ? ((level_reg[gi] == LEVEL_MAX) || (level_reg[gi] > pwm_cnt_reg))
                : led_q_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q_reg   <= '0;
            level_reg   <= '0;
            pwm_cnt_reg <= '0;
            presc_reg   <= '0;
            led_out_reg <= '0;
        end else begin
            led_q_reg   <= led_in;
            level_reg   <= level_next;
            led_out_reg <= led_out_next;
            if (enable) begin
                pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
                presc_reg   <= tick ? '0 : presc_reg + PRESC_W'(1);
            end
        end
    end

    assign led_out = led_out_reg;

`ifdef LED_FADE_DONE_EN
    logic [NUM_LEDS-1:0] chan_settled;
    logic                settled;
    logic                settled_d_reg;
    logic                fade_done_reg;

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_settle
            assign chan_settled[gi] =
                (level_reg[gi] == (led_q_reg[gi] ? LEVEL_MAX : '0));
        end
    endgenerate

    assign settled = &chan_settled;

    // settled_d starts at 1 so leaving reset (where everything is trivially
    // settled) does not look like a fresh rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            settled_d_reg <= 1'b1;
            fade_done_reg <= 1'b0;
        end else begin
            settled_d_reg <= settled;
            fade_done_reg <= settled && !settled_d_reg;
        end
    end

    assign fade_done = fade_done_reg;
`endif

endmodule

// File: tb/tb_mnist_nn_led_fader.sv
// -----------------------------------------------------------------------------
// Testbench for mnist_nn_led_fader (NUM_LEDS=14, PWM_BITS=4, STEP_DIV=2).
// A behavioural model tracks brightness levels as integers and predicts
// led_out (and fade_done when LED_FADE_DONE_EN is defined) every cycle.
// -----------------------------------------------------------------------------
module tb_mnist_nn_led_fader;

    localparam int N    = 14;
    localparam int PB   = 4;
    localparam int SDIV = 2;
    localparam int LMAX = (1 << PB) - 1;

    logic         clk;
    logic         reset;
    logic         enable;
    logic [N-1:0] led_in;
    logic [N-1:0] led_out;
`ifdef LED_FADE_DONE_EN
    logic         fade_done;
`endif

    mnist_nn_led_fader #(
        .NUM_LEDS(N),
        .PWM_BITS(PB),
        .STEP_DIV(SDIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .led_in   (led_in),
        .led_out  (led_out)
`ifdef LED_FADE_DONE_EN
        ,
        .fade_done(fade_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    int           m_level[N];
    int           m_pwm;
    int           m_presc;
    logic [N-1:0] m_q;
    logic [N-1:0] m_out;
    logic         m_sd;
    logic         m_fd;

    // Advance the model by one clock using the inputs present at the edge,
    // then let the DUT take the same edge and settle.
    task automatic step();
        int           nl[N];
        logic [N-1:0] no;
        logic         tk;
        logic         st;
        int           np, nps;
        logic         nsd, nfd;
        if (reset) begin
            for (int i = 0; i < N; i++) nl[i] = 0;
            no = '0; np = 0; nps = 0; nsd = 1'b1; nfd = 1'b0;
        end else begin
            tk = enable && (m_presc == SDIV - 1);
            st = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (m_level[i] != (m_q[i] ? LMAX : 0)) st = 1'b0;
                no[i] = enable ? ((m_level[i] == LMAX) || (m_level[i] > m_pwm)) : m_q[i];
                nl[i] = m_level[i];
                if (tk) begin
                    if (m_q[i] && nl[i] < LMAX) nl[i] = nl[i] + 1;
                    else if (!m_q[i] && nl[i] > 0) nl[i] = nl[i] - 1;
                end
            end
            np  = enable ? (m_pwm + 1) % (LMAX + 1) : m_pwm;
            nps = enable ? (tk ? 0 : m_presc + 1) : m_presc;
            nsd = st;
            nfd = st && !m_sd;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) m_level[i] = nl[i];
        m_out   = no;
        m_pwm   = np;
        m_presc = nps;
        m_q     = reset ? '0 : led_in;
        m_sd    = nsd;
        m_fd    = nfd;
        cyc++;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        led_in = 14'h3FFF;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (led_out !== 14'h0000) begin
                errors++;
                $display("FAIL reset_led_out cyc=%0d got=%h exp=0000", cyc, led_out);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (dut.level_reg[i] !== 4'd0) begin
                    errors++;
                    $display("FAIL reset_level[%0d] cyc=%0d got=%0d exp=0", i, cyc, dut.level_reg[i]);
                end
            end
        end
        reset = 1'b0;
        step();
        checks++;
        if (led_out !== 14'h0000) begin
            errors++;
            $display("FAIL post_reset_led_out cyc=%0d got=%h exp=0000", cyc, led_out);
        end
        led_in = '0;
        for (int k = 0; k < 40; k++) begin
            step();
            checks++;
            if (led_out !== m_out) begin
                errors++;
                $display("FAIL settle_led_out cyc=%0d got=%h exp=%h", cyc, led_out, m_out);
            end
        end
        $display("test_reset done cyc=%0d", cyc);
    endtask

    task automatic test_ramp_up();
        led_in = 14'h0001;
        for (int k = 0; k < 40; k++) begin
            step();
            checks++;
            if (led_out !== m_out || int'(dut.level_reg[0]) != m_level[0]) begin
                errors++;
                $display("FAIL ramp cyc=%0d got_out=%h exp_out=%h got_lvl=%0d exp_lvl=%0d",
                         cyc, led_out, m_out, dut.level_reg[0], m_level[0]);
            end
        end
        checks++;
        if (dut.level_reg[0] !== 4'd15) begin
            errors++;
            $display("FAIL ramp_top cyc=%0d got=%0d exp=15", cyc, dut.level_reg[0]);
        end
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if (led_out[0] !== 1'b1) begin
                errors++;
                $display("FAIL ramp_full_on cyc=%0d got=%b exp=1", cyc, led_out[0]);
            end
        end
        $display("test_ramp_up done cyc=%0d", cyc);
    endtask

    task automatic test_reversal();
        logic [N-1:0] others;
        int           budget;
        others = N'($urandom) & 14'h3FFE;
        led_in = others;
        budget = 0;
        while (m_level[0] != 0 && budget < 100) begin step(); budget++; end
        led_in = others | 14'h0001;
        budget = 0;
        while (m_level[0] != 8 && budget < 100) begin step(); budget++; end
        checks++;
        if (budget >= 100) begin
            errors++;
            $display("FAIL reversal_reach8 cyc=%0d got=%0d exp=8", cyc, m_level[0]);
        end
        led_in = others;
        for (int k = 0; k < 40; k++) begin
            step();
            checks++;
            if (led_out !== m_out || int'(dut.level_reg[0]) != m_level[0]) begin
                errors++;
                $display("FAIL reversal cyc=%0d got_out=%h exp_out=%h got_lvl=%0d exp_lvl=%0d",
                         cyc, led_out, m_out, dut.level_reg[0], m_level[0]);
            end
        end
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if (led_out[0] !== 1'b0 || dut.level_reg[0] !== 4'd0) begin
                errors++;
                $display("FAIL reversal_off cyc=%0d got_out0=%b got_lvl=%0d exp=0",
                         cyc, led_out[0], dut.level_reg[0]);
            end
        end
        $display("test_reversal done cyc=%0d others=%h", cyc, others);
    endtask

    task automatic test_bypass();
        led_in = 14'h0F0F;
        for (int k = 0; k < 7; k++) step();
        enable = 1'b0;
        led_in = 14'h2A55;
        step();
        checks++;
        if (led_out !== m_out) begin
            errors++;
            $display("FAIL bypass_first cyc=%0d got=%h exp=%h", cyc, led_out, m_out);
        end
        step();
        checks++;
        if (led_out !== 14'h2A55) begin
            errors++;
            $display("FAIL bypass_out cyc=%0d got=%h exp=2a55", cyc, led_out);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (int'(dut.pwm_cnt_reg) != m_pwm || int'(dut.presc_reg) != m_presc) begin
                errors++;
                $display("FAIL bypass_hold cyc=%0d got_pwm=%0d exp_pwm=%0d got_presc=%0d exp_presc=%0d",
                         cyc, dut.pwm_cnt_reg, m_pwm, dut.presc_reg, m_presc);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (int'(dut.level_reg[i]) != m_level[i]) begin
                    errors++;
                    $display("FAIL bypass_level[%0d] cyc=%0d got=%0d exp=%0d",
                             i, cyc, dut.level_reg[i], m_level[i]);
                end
            end
        end
        enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            checks++;
            if (led_out !== m_out) begin
                errors++;
                $display("FAIL resume cyc=%0d got=%h exp=%h", cyc, led_out, m_out);
            end
        end
        $display("test_bypass done cyc=%0d", cyc);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) led_in = N'($urandom);
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            step();
            checks++;
            if (led_out !== m_out) begin
                errors++;
                $display("FAIL random_out cyc=%0d got=%h exp=%h", cyc, led_out, m_out);
            end
`ifdef LED_FADE_DONE_EN
            checks++;
            if (fade_done !== m_fd) begin
                errors++;
                $display("FAIL random_fade_done cyc=%0d got=%b exp=%b", cyc, fade_done, m_fd);
            end
`endif
        end
        enable = 1'b1;
        $display("test_random done cyc=%0d", cyc);
    endtask

    task automatic test_reset_mid_fade();
        int budget;
        led_in = '0;
        budget = 0;
        while (m_level[3] != 0 && budget < 100) begin step(); budget++; end
        led_in = 14'h0008;
        budget = 0;
        while (!(m_level[3] == 9 && m_presc == SDIV - 1) && budget < 100) begin
            step(); budget++;
        end
        checks++;
        if (budget >= 100) begin
            errors++;
            $display("FAIL midfade_reach9 cyc=%0d got=%0d exp=9", cyc, m_level[3]);
        end
        checks++;
        if (dut.level_reg[3] !== 4'd9) begin
            errors++;
            $display("FAIL midfade_pre cyc=%0d got=%0d exp=9", cyc, dut.level_reg[3]);
        end
        reset = 1'b1;
        step();
        checks++;
        if (dut.level_reg[3] !== 4'd0 || led_out !== 14'h0000) begin
            errors++;
            $display("FAIL midfade_reset cyc=%0d got_lvl=%0d got_out=%h exp=0", cyc, dut.level_reg[3], led_out);
        end
        reset = 1'b0;
        step();
        $display("test_reset_mid_fade done cyc=%0d", cyc);
    endtask

`ifdef LED_FADE_DONE_EN
    task automatic test_fade_done();
        int pulses;
        int budget;
        led_in = '0;
        budget = 0;
        while (m_level[0] != 0 && budget < 100) begin step(); budget++; end
        for (int k = 0; k < 4; k++) step();
        led_in = 14'h0001;
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (fade_done === 1'b1) pulses++;
            checks++;
            if (fade_done !== m_fd) begin
                errors++;
                $display("FAIL fade_done_timing cyc=%0d got=%b exp=%b", cyc, fade_done, m_fd);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL fade_done_count got=%0d exp=1", pulses);
        end
        led_in = 14'h0001;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (fade_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL fade_done_rewrite got=%0d exp=0", pulses);
        end
        $display("test_fade_done done cyc=%0d", cyc);
    endtask
`endif

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        led_in = '0;
        for (int i = 0; i < N; i++) m_level[i] = 0;
        m_pwm = 0; m_presc = 0; m_q = '0; m_out = '0; m_sd = 1'b1; m_fd = 1'b0;
        test_reset();
        test_ramp_up();
        test_reversal();
        test_bypass();
        test_random();
        test_reset_mid_fade();
`ifdef LED_FADE_DONE_EN
        test_fade_done();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
